// File: rtl/siso_shift_register.sv
// Serial-in serial-out bit delay line: each bit sampled on s_in appears on s_out
// DEPTH clocks later. Synchronous active-high clear empties every stage.
module siso_shift_register #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic s_in,
    output logic s_out
);

    // q[0] is the input stage, q[DEPTH-1] drives s_out directly.
    logic [DEPTH-1:0] q;

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else begin
            q <= {q[DEPTH-2:0], s_in};
        end
    end

    assign s_out = q[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_register.sv
// Directed bench for siso_shift_register (DEPTH=4): reset, pattern, latency,
// mid-stream clear, sub-cycle clear pulse and X-neighbour integrity.
module tb_siso_shift_register;

    localparam int DEPTH = 4;

    logic clk;
    logic clear;
    logic s_in;
    logic s_out;

    int checks_total;
    int checks_passed;

    siso_shift_register #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .clear (clear),
        .s_in  (s_in),
        .s_out (s_out)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end else begin
            checks_passed++;
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic drive(input logic d, input logic c);
        @(negedge clk);
        s_in  = d;
        clear = c;
        @(posedge clk);
        #1;
    endtask

    logic pat_in  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic pat_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic x_in   [8] = '{1'b1, 1'b0, 1'bx, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic x_exp  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic x_skip [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        s_in  = 1'b0;
        clear = 1'b0;

        // Reset with s_in held high: zero for 3 edges after deassert, then 1.
        drive(1'b1, 1'b1);
        check_bit("reset_zero", s_out, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1'b1, 1'b0);
            check_bit("reset_hold_zero", s_out, 1'b0);
        end
        drive(1'b1, 1'b0);
        check_bit("reset_first_one", s_out, 1'b1);

        // Pattern 1,0,0,1,0 followed by zeros.
        drive(1'b0, 1'b1);
        check_bit("pattern_clear", s_out, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(pat_in[i], 1'b0);
            check_bit($sformatf("pattern_%0d", i), s_out, pat_exp[i]);
        end

        // Lone pulse: high for exactly one cycle, DEPTH-1 edges after capture.
        drive(1'b1, 1'b0);
        check_bit("pulse_capture", s_out, 1'b0);
        drive(1'b0, 1'b0);
        check_bit("pulse_wait1", s_out, 1'b0);
        drive(1'b0, 1'b0);
        check_bit("pulse_wait2", s_out, 1'b0);
        drive(1'b0, 1'b0);
        check_bit("pulse_high", s_out, 1'b1);
        drive(1'b0, 1'b0);
        check_bit("pulse_low_after", s_out, 1'b0);
        drive(1'b0, 1'b0);
        check_bit("pulse_low_after2", s_out, 1'b0);

        // Fill with ones, then clear mid-stream with s_in=1 (discarded).
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0);
            check_bit($sformatf("fill_%0d", i), s_out, (i == DEPTH - 1) ? 1'b1 : 1'b0);
        end
        drive(1'b1, 1'b1);
        check_bit("midclear_zero", s_out, 1'b0);
        drive(1'b1, 1'b1);
        check_bit("midclear_held", s_out, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1'b1, 1'b0);
            check_bit("midclear_refill_zero", s_out, 1'b0);
        end
        drive(1'b1, 1'b0);
        check_bit("midclear_refill_one", s_out, 1'b1);

        // Load 1,0,1,1 then pulse clear entirely within the low phase.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        check_bit("short_pre", s_out, 1'b1);
        @(negedge clk);
        s_in = 1'b0;
        #1 clear = 1'b1;
        #2 clear = 1'b0;
        #1;
        check_bit("short_during", s_out, 1'b1);
        @(posedge clk);
        #1;
        check_bit("short_out0", s_out, 1'b0);
        drive(1'b0, 1'b0);
        check_bit("short_out1", s_out, 1'b1);
        drive(1'b0, 1'b0);
        check_bit("short_out2", s_out, 1'b1);
        drive(1'b0, 1'b0);
        check_bit("short_out3", s_out, 1'b0);

        // Unknown bit sandwiched between known bits; neighbours must survive.
        for (int i = 0; i < 8; i++) begin
            drive(x_in[i], 1'b0);
            if (!x_skip[i]) begin
                check_bit($sformatf("xprop_%0d", i), s_out, x_exp[i]);
            end
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
